instruction_cache: RTL and testbench

- Direct-mapped instruction cache that sits between the CPU fetch stage and the 128-bit line-read instruction memory.
- Returns 32-bit instructions in the same cycle on a hit.
- On a miss, drives a line-aligned address to the memory and waits a fixed number of edges with the address held stable. It then captures the 128-bit line, installs it, and serves the fetch from the cache.

---
 rtl/instruction_cache.sv | 153 +++++++++++++++
 tb/tb_instruction_cache.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_cache.sv
// Direct-mapped instruction cache, 32-bit hit path, 128-bit line fill.
// Optional hit/miss counters: define INSTRUCTION_CACHE_STATS_EN.
module instruction_cache #(
  parameter int NUM_LINES      = 16,
  parameter int MEMORY_LATENCY = 6
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         cpu_read_request,
  input  logic [31:0]  cpu_address,
  input  logic         cache_flush,
  output logic [31:0]  cpu_instruction,
  output logic         cpu_ready,
  output logic [31:0]  memory_address,
  input  logic [127:0] memory_data_line
`ifdef INSTRUCTION_CACHE_STATS_EN
  ,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
`endif
);

  localparam int IB = $clog2(NUM_LINES);
  localparam int TB = 28 - IB;
  localparam int CW = $clog2(MEMORY_LATENCY + 1);

  typedef enum logic {
    S_IDLE,
    S_FILL
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [NUM_LINES-1:0] r_valid;
  logic [TB-1:0]        r_tag  [NUM_LINES];
  logic [127:0]         r_data [NUM_LINES];
  logic [IB-1:0]        r_fill_idx;
  logic [TB-1:0]        r_fill_tag;
  logic [31:0]          r_mem_addr;
  logic [CW-1:0]        r_cnt;

  logic [IB-1:0] w_idx;
  logic [TB-1:0] w_tag;
  logic [1:0]    w_word;
  logic [127:0]  w_line;
  logic          w_hit;
  logic          w_start;
  logic          w_capture;
  logic          w_unused;

  assign w_idx          = cpu_address[3+IB:4];
  assign w_tag          = cpu_address[31:4+IB];
  assign w_word         = cpu_address[3:2];
  assign w_line         = r_data[w_idx];
  assign w_hit          = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_unused       = ^cpu_address[1:0];
  assign memory_address = r_mem_addr;

  // Big-endian word select out of the indexed line
  always_comb begin
    cpu_instruction = w_line[127:96];
    unique case (w_word)
      2'd0: cpu_instruction = w_line[127:96];
      2'd1: cpu_instruction = w_line[95:64];
      2'd2: cpu_instruction = w_line[63:32];
      2'd3: cpu_instruction = w_line[31:0];
    endcase
  end

  // Next state, hit response and fill start/capture strobes
  always_comb begin
    w_next    = r_state;
    w_start   = 1'b0;
    w_capture = 1'b0;
    cpu_ready = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        cpu_ready = cpu_read_request && w_hit && !cache_flush;
        if (cpu_read_request && !w_hit && !cache_flush) begin
          w_start = 1'b1;
          w_next  = S_FILL;
        end
      end
      S_FILL: begin
        if (cache_flush) begin
          w_next = S_IDLE;
        end else if (r_cnt == CW'(MEMORY_LATENCY)) begin
          w_capture = 1'b1;
          w_next    = S_IDLE;
        end
      end
    endcase
    if (!reset_n) begin
      cpu_ready = 1'b0;
      w_start   = 1'b0;
      w_capture = 1'b0;
      w_next    = S_IDLE;
    end
  end

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Valid bits, memory address and fill wait counter
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_valid    <= '0;
      r_mem_addr <= '0;
      r_cnt      <= '0;
    end else begin
      if (cache_flush)    r_valid <= '0;
      else if (w_capture) r_valid[r_fill_idx] <= 1'b1;
      if (w_start) begin
        r_mem_addr <= {cpu_address[31:4], 4'b0000};
        r_cnt      <= '0;
      end else if (r_state == S_FILL && !w_capture) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // Miss target latch and line install (arrays are never reset)
  always_ff @(posedge clock) begin
    if (w_start) begin
      r_fill_idx <= w_idx;
      r_fill_tag <= w_tag;
    end
    if (w_capture) begin
      r_data[r_fill_idx] <= memory_data_line;
      r_tag[r_fill_idx]  <= r_fill_tag;
    end
  end

`ifdef INSTRUCTION_CACHE_STATS_EN
  // Saturating hit/miss counters, untouched by flush
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (r_state == S_IDLE && cpu_ready && hit_count != '1)
        hit_count <= hit_count + 32'd1;
      if (w_start && miss_count != '1)
        miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// Bench for instruction_cache: reference model plus directed fetch sequences.
// Memory presents garbage until the address has been stable long enough.
module tb_instruction_cache;

  localparam int ML = 6;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         cpu_read_request;
  logic [31:0]  cpu_address;
  logic         cache_flush;
  logic [31:0]  cpu_instruction;
  logic         cpu_ready;
  logic [31:0]  memory_address;
  logic [127:0] memory_data_line;
`ifdef INSTRUCTION_CACHE_STATS_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  instruction_cache #(.NUM_LINES(16), .MEMORY_LATENCY(ML)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .cpu_read_request (cpu_read_request),
    .cpu_address      (cpu_address),
    .cache_flush      (cache_flush),
    .cpu_instruction  (cpu_instruction),
    .cpu_ready        (cpu_ready),
    .memory_address   (memory_address),
    .memory_data_line (memory_data_line)
`ifdef INSTRUCTION_CACHE_STATS_EN
    ,
    .hit_count        (hit_count),
    .miss_count       (miss_count)
`endif
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int fails   = 0;
  bit chk_en  = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] mbyte(input logic [31:0] a);
    logic [7:0] lo;
    lo = a[7:0] - 8'h40;
    return lo ^ a[15:8];
  endfunction

  function automatic logic [127:0] mline(input logic [31:0] a);
    logic [127:0] l;
    logic [31:0]  base;
    base = {a[31:4], 4'b0000};
    for (int i = 0; i < 16; i++) l[127-8*i -: 8] = mbyte(base + i);
    return l;
  endfunction

  function automatic logic [31:0] mword(input logic [31:0] a);
    logic [127:0] l;
    int           k;
    l = mline(a);
    k = int'(a[3:2]);
    return l[127-32*k -: 32];
  endfunction

  // Instruction memory: valid only after ML stable edges
  logic [31:0] mem_last = 32'hFFFF_FFFF;
  int          mem_stable = 0;
  always @(negedge clock) begin
    if (memory_address !== mem_last) begin
      mem_last   = memory_address;
      mem_stable = 0;
    end else if (mem_stable < 1000) begin
      mem_stable++;
    end
    if (mem_stable >= ML) memory_data_line = mline(memory_address);
    else                  memory_data_line = {4{32'hDEAD_BEEF}};
  end

  // Reference model: which line address each slot holds, pending fill
  logic [31:0] res [16];
  bit          resv [16];
  bit          pend = 0;
  int          done_at;
  int          edge_no = 0;
  logic [31:0] pend_line;
  logic [31:0] exp_maddr = 32'h0;
  int          m_hits = 0;
  int          m_misses = 0;

  function automatic bit m_hit(input logic [31:0] a);
    int idx;
    idx = int'(a[7:4]);
    return resv[idx] && (res[idx] == {a[31:4], 4'b0000});
  endfunction

  always @(posedge clock) begin
    edge_no++;
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) resv[i] = 0;
      pend = 0; exp_maddr = 0; m_hits = 0; m_misses = 0;
    end else if (cache_flush) begin
      for (int i = 0; i < 16; i++) resv[i] = 0;
      pend = 0;
    end else if (pend) begin
      if (edge_no == done_at) begin
        res[int'(pend_line[7:4])]  = pend_line;
        resv[int'(pend_line[7:4])] = 1;
        pend = 0;
      end
    end else if (cpu_read_request) begin
      if (m_hit(cpu_address)) begin
        m_hits++;
      end else begin
        pend      = 1;
        done_at   = edge_no + ML + 1;
        pend_line = {cpu_address[31:4], 4'b0000};
        exp_maddr = pend_line;
        m_misses++;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clock) begin
    if (chk_en) begin
      logic er;
      er = reset_n && !cache_flush && !pend && cpu_read_request
           && m_hit(cpu_address);
      check("ready", {31'b0, cpu_ready}, {31'b0, er});
      if (er) check("instr", cpu_instruction, mword(cpu_address));
      check("maddr", memory_address, exp_maddr);
`ifdef INSTRUCTION_CACHE_STATS_EN
      check("hits", hit_count, m_hits);
      check("misses", miss_count, m_misses);
`endif
    end
  end

  // Request a word and measure edges until it is served
  task automatic fetch(input logic [31:0] a, input int exp_n,
                       input logic [31:0] exp_w);
    int n;
    n = 0;
    cpu_address      = a;
    cpu_read_request = 1'b1;
    #1;
    while (!cpu_ready && n < 40) begin
      @(posedge clock); #2;
      n++;
      if (n == 1 && exp_n > 0)
        check("maddr_first", memory_address, {a[31:4], 4'b0000});
    end
    check("latency", n, exp_n);
    check("word", cpu_instruction, exp_w);
  endtask

  task automatic step();
    @(posedge clock); #2;
  endtask

  initial begin
    int n;
    reset_n          = 1'b0;
    cpu_read_request = 1'b0;
    cpu_address      = 32'h0;
    cache_flush      = 1'b0;
    memory_data_line = '0;
    @(posedge clock);
    chk_en = 1;
    @(posedge clock); #2;
    reset_n = 1'b1;
    #1;
    check("rst_ready", {31'b0, cpu_ready}, 32'h0);
    check("rst_maddr", memory_address, 32'h0);

    step();
    fetch(32'h44, 8, 32'h0405_0607);
    step();
    fetch(32'h4C, 0, 32'h0C0D_0E0F);
    step();
    cpu_read_request = 1'b0;
`ifdef INSTRUCTION_CACHE_STATS_EN
    #1;
    check("stat_hits", hit_count, 32'd2);
    check("stat_misses", miss_count, 32'd1);
`endif

    step();
    fetch(32'h140, 8, 32'h0100_0302);
    step();
    fetch(32'h40, 8, 32'h0001_0203);

    step();
    cpu_address      = 32'h80;
    cpu_read_request = 1'b1;
    repeat (4) @(posedge clock);
    #2;
    cpu_address = 32'h200;
    n = 0;
    #1;
    while (!cpu_ready && n < 40) begin
      @(posedge clock); #2;
      n++;
    end
    check("chg_latency", n, 12);
    check("chg_word", cpu_instruction, 32'hC2C3_C0C1);
    check("chg_maddr", memory_address, 32'h200);
    step();
    fetch(32'h80, 0, 32'h4041_4243);

    step();
    cpu_read_request = 1'b0;
    cache_flush      = 1'b1;
    step();
    cache_flush = 1'b0;
    fetch(32'h40, 8, 32'h0001_0203);

    step();
    cpu_address = 32'h140;
    repeat (4) @(posedge clock);
    #2;
    cpu_read_request = 1'b0;
    cache_flush      = 1'b1;
    step();
    cache_flush = 1'b0;
    #1;
    check("abort_maddr", memory_address, 32'h140);
    fetch(32'h140, 8, 32'h0100_0302);
    step();
    cache_flush = 1'b1;
    #1;
    check("flush_ready", {31'b0, cpu_ready}, 32'h0);
    step();
    cache_flush      = 1'b0;
    cpu_read_request = 1'b0;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
